// File: rtl/line_window_3x3.sv
// line_window_3x3
//
// Turns a raster-order pixel stream into 3x3 neighbourhood windows. Two line
// buffers hold the previous two lines. Three 3-deep shift registers hold the
// columns of the current window. A window is emitted only when its
// bottom-right pixel sits at row >= 2 and col >= 2. As a result, no window
// spans a line wrap or contains stale data from before a frame restart.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_pixel / in_sof are valid
//   in_ready   : a pixel can be accepted this cycle
//   in_pixel   : raster-order pixel
//   in_sof     : pixel is frame position (0,0)
//   out_valid  : out_window / out_eof are valid
//   out_ready  : downstream accepts the window
//   out_window : 3x3 window, row-major, [0] top-left .. [8] bottom-right
//   out_eof    : window is the last one of the frame
module line_window_3x3 #(
    parameter int unsigned NBIT       = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] in_pixel,
    input  logic            in_sof,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] out_window [0:8],
    output logic            out_eof
);

    localparam int unsigned ColW = $clog2(IMG_WIDTH);
    localparam int unsigned RowW = $clog2(IMG_HEIGHT);

    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
    localparam logic [ColW-1:0] ColTwo  = ColW'(2);
    localparam logic [RowW-1:0] RowTwo  = RowW'(2);
    localparam logic [ColW-1:0] ColOne  = ColW'(1);
    localparam logic [RowW-1:0] RowOne  = RowW'(1);

    // Position counters for the next pixel to be accepted.
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;

    // Effective position of the pixel currently presented. in_sof forces (0,0).
    logic [ColW-1:0] pos_col;
    logic [RowW-1:0] pos_row;

    logic accept;
    logic make_window;
    logic last_window;

    // lb_near holds line r-1 and lb_far holds line r-2, indexed by column.
    logic [NBIT-1:0] lb_near_q [IMG_WIDTH];
    logic [NBIT-1:0] lb_far_q  [IMG_WIDTH];
    logic [NBIT-1:0] lb_near_rd;
    logic [NBIT-1:0] lb_far_rd;

    // Horizontal shift registers. Index 0 is the oldest (left) column.
    logic [0:2][NBIT-1:0] sr_top_q;
    logic [0:2][NBIT-1:0] sr_mid_q;
    logic [0:2][NBIT-1:0] sr_bot_q;

    logic out_valid_q;
    logic out_eof_q;

    // Handshake: no buffering beyond the single output register.
    assign in_ready = out_ready || !out_valid_q;
    assign accept   = in_valid && in_ready;

    assign pos_col = in_sof ? '0 : col_q;
    assign pos_row = in_sof ? '0 : row_q;

    assign lb_near_rd = lb_near_q[pos_col];
    assign lb_far_rd  = lb_far_q[pos_col];

    // Row gating also discards stale line-buffer data after a restart.
    assign make_window = (pos_row >= RowTwo) && (pos_col >= ColTwo);
    assign last_window = (pos_row == RowLast) && (pos_col == ColLast);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (pos_col == ColLast) begin
                col_d = '0;
                row_d = (pos_row == RowLast) ? '0 : pos_row + RowOne;
            end else begin
                col_d = pos_col + ColOne;
                row_d = pos_row;
            end
        end
    end

    // Line buffers are not reset. Row gating keeps their contents off the output.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_near_q[pos_col] <= in_pixel;
            lb_far_q[pos_col]  <= lb_near_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            sr_top_q    <= '0;
            sr_mid_q    <= '0;
            sr_bot_q    <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (accept) begin
                sr_top_q    <= {sr_top_q[1], sr_top_q[2], lb_far_rd};
                sr_mid_q    <= {sr_mid_q[1], sr_mid_q[2], lb_near_rd};
                sr_bot_q    <= {sr_bot_q[1], sr_bot_q[2], in_pixel};
                out_valid_q <= make_window;
                out_eof_q   <= make_window && last_window;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_eof_q   <= 1'b0;
            end
        end
    end

    // The window is read straight out of the shift registers. They only move
    // on accept, and no accept happens while a window is stalled, so the
    // window holds stable during backpressure.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            out_window[k]     = sr_top_q[k];
            out_window[3 + k] = sr_mid_q[k];
            out_window[6 + k] = sr_bot_q[k];
        end
    end

    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Bench for line_window_3x3 on a 4x4 image. The stimulus process pushes the
// expected windows into a queue. A monitor process pops and compares them
// on every output transfer.
module tb_line_window_3x3;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_sof    = 1'b0;
    logic [7:0] in_pixel  = 8'd0;
    logic       ready_cmd = 1'b1;
    logic       rand_mode = 1'b0;
    logic       rnd_bit   = 1'b1;
    logic       gaps      = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_eof;
    logic [7:0] out_window [0:8];

    typedef struct packed {
        logic [8:0][7:0] win;
        logic            eof;
    } exp_t;

    exp_t       exp_q [$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] base_win [4][9];
    logic [7:0] frame [W*H];

    line_window_3x3 #(
        .NBIT      (8),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_window(out_window),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    assign out_ready = rand_mode ? rnd_bit : ready_cmd;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [8:0][7:0] pack_out();
        logic [8:0][7:0] p;
        for (int i = 0; i < 9; i++) p[i] = out_window[i];
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_win(input string name, input logic [8:0][7:0] req);
        logic [8:0][7:0] act;
        act = pack_out();
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: one pop per output transfer.
    initial begin
        exp_t            e;
        logic [8:0][7:0] got;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                got = pack_out();
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_window: got %h required no window", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e.win) begin
                        bad++;
                        $display("FAIL window: got %h required %h", got, e.win);
                    end
                    total++;
                    if (out_eof !== e.eof) begin
                        bad++;
                        $display("FAIL eof: got %b required %b", out_eof, e.eof);
                    end
                end
            end
        end
    end

    task automatic push_base(input logic [7:0] offset);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 9; i++) e.win[i] = base_win[k][i] + offset;
            e.eof = (k == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_model();
        exp_t e;
        for (int wr = 0; wr < H - 2; wr++) begin
            for (int wc = 0; wc < W - 2; wc++) begin
                for (int i = 0; i < 9; i++) e.win[i] = frame[(wr + i / 3) * W + wc + i % 3];
                e.eof = (wr == H - 3) && (wc == W - 3);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_pixel(input logic [7:0] p, input logic sof);
        int n;
        logic acc;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = sof;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [8:0][7:0] w1;
        base_win = '{'{8'd0, 8'd1, 8'd2,  8'd4, 8'd5,  8'd6,  8'd8,  8'd9,  8'd10},
                     '{8'd1, 8'd2, 8'd3,  8'd5, 8'd6,  8'd7,  8'd9,  8'd10, 8'd11},
                     '{8'd4, 8'd5, 8'd6,  8'd8, 8'd9,  8'd10, 8'd12, 8'd13, 8'd14},
                     '{8'd5, 8'd6, 8'd7,  8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}};
        for (int i = 0; i < 9; i++) w1[i] = base_win[1][i];

        // Reset values
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_eof", {31'd0, out_eof}, 32'd0);
        check("rst_window_zero", {31'd0, |pack_out()}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic frame with a latency check around pixel 10
        push_base(8'd0);
        for (int i = 0; i < 10; i++) send_pixel(8'(i), i == 0);
        check("no_window_before_px10", {31'd0, out_valid}, 32'd0);
        send_pixel(8'd10, 1'b0);
        check("first_window_latency", {31'd0, out_valid}, 32'd1);
        for (int i = 11; i < 16; i++) send_pixel(8'(i), 1'b0);
        drain();

        // Backpressure for 3 cycles on the second window
        push_base(8'd0);
        for (int i = 0; i < 12; i++) send_pixel(8'(i), i == 0);
        ready_cmd = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = 8'd12;
        in_sof    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check_win("stall_window_held", w1);
            @(posedge clk);
            #1;
        end
        ready_cmd = 1'b1;
        for (int i = 12; i < 16; i++) send_pixel(8'(i), 1'b0);
        drain();

        // Two back-to-back frames
        push_base(8'd0);
        push_base(8'd0);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) send_pixel(8'(i), i == 0);
        drain();

        // Restart via in_sof at pixel 7
        for (int i = 0; i < 7; i++) send_pixel(8'(i), i == 0);
        push_base(8'd16);
        for (int i = 0; i < 16; i++) send_pixel(8'(16 + i), i == 0);
        drain();

        // Reset while a window is being held
        for (int i = 0; i < 10; i++) send_pixel(8'(i), i == 0);
        ready_cmd = 1'b0;
        send_pixel(8'd10, 1'b0);
        check("held_before_reset", {31'd0, out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_eof", {31'd0, out_eof}, 32'd0);
        check("reset_window_zero", {31'd0, |pack_out()}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        ready_cmd = 1'b1;
        push_base(8'd0);
        for (int i = 0; i < 16; i++) send_pixel(8'(i), 1'b0);
        drain();

        // Frames with random pixel values, input gaps and output backpressure
        rand_mode = 1'b1;
        gaps      = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < W * H; i++) frame[i] = 8'($urandom_range(0, 255));
            push_model();
            for (int i = 0; i < W * H; i++) send_pixel(frame[i], i == 0);
        end
        rand_mode = 1'b0;
        gaps      = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_window_3x3.md
LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 SHALL have parameter NBIT, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, pixels per line (≥3).
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (≥3).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_pixel/in_sof are valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a pixel this cycle.
REQ-008 SHALL have port in_pixel  input  NBIT  raster-order pixel.
REQ-009 SHALL have port in_sof  input  1  pixel is frame position (0,0).
REQ-010 SHALL have port out_valid  output  1  out_window/out_eof are valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the window.
REQ-012 SHALL have port out_window  output  NBIT x 9 (unpacked [0:8])  3x3 window, row-major; index 0 top-left, 8 bottom-right; formatted to drive the 9-input adder tree directly.
REQ-013 SHALL have port out_eof  output  1  window is the last one of the frame.

Function
REQ-014 Input accept SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL equal out_ready || !out_valid (combinational; no deeper buffering).
REQ-016 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) for the next pixel to be accepted; both advance only on accept.
REQ-017 On accept, col SHALL increment, wrapping to 0 at IMG_WIDTH-1 with row incrementing; row SHALL wrap to 0 after (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-018 An accepted pixel with in_sof=1 SHALL be treated as position (0,0) regardless of counters; counters then become (0,1).
REQ-019 SHALL store two previous lines in two IMG_WIDTH-deep line buffers (pixel at (r,c) readable as line r-1 and r-2 when accepting (r+1,c) and (r+2,c)).
REQ-020 SHALL maintain three 3-deep horizontal shift registers (rows r-2, r-1, r) advancing only on accept.
REQ-021 When a pixel at (r,c) with r≥2 and c≥2 is accepted, out_window SHALL on the next cycle hold pixels (r-2..r, c-2..c) and out_valid SHALL be 1; latency exactly 1 cycle.
REQ-022 Accepts with r<2 or c<2 SHALL update storage but SHALL NOT produce a window (out_valid falls to 0 after any pending window transfers).
REQ-023 Windows SHALL never mix pixels across a line wrap; exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-024 out_eof SHALL be 1 only with the window whose bottom-right pixel is (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-025 While out_valid && !out_ready, out_window, out_eof and out_valid SHALL hold stable and no input SHALL be accepted.
REQ-026 Simultaneous output transfer and input accept in one cycle SHALL be supported (full throughput, one pixel/cycle).
REQ-027 in_sof mid-frame SHALL abandon the current frame; stale line-buffer contents SHALL not be emitted as windows (row<2 gating suffices).
REQ-028 Pixel data SHALL pass unmodified (no arithmetic, no padding).

Reset
REQ-029 On rst_n=0, SHALL asynchronously clear out_valid=0, out_eof=0, out_window all 0, row=0, col=0, shift registers 0.
REQ-030 Line-buffer contents need not be cleared; they SHALL never reach out_window before being rewritten in the new frame.
REQ-031 in_ready SHALL read 1 during and after reset (out_valid=0).
REQ-032 Reset asserted mid-frame SHALL discard the frame; first pixel after release is (0,0) with or without in_sof.

Verification
REQ-033 IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15 streamed, out_ready=1 -> 4 windows: {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15} (sums 45,54,81,90); first valid cycle after pixel 10 accepted; out_eof only on last.
REQ-034 Same stimulus, out_ready low 3 cycles on the second window -> window held stable, in_ready=0 those cycles, no pixel lost, identical window sequence.
REQ-035 Two back-to-back frames (second with in_sof=1) -> 8 windows, second frame's first window {0,1,2,4,5,6,8,9,10}, no cross-frame window.
REQ-036 in_sof asserted at pixel 7 of a frame -> no window until new row 2, col 2; windows match restarted frame.
REQ-037 rst_n pulsed low after pixel 9 -> out_valid=0 immediately; restreamed 0..15 gives REQ-033 result.
REQ-038 in_valid toggling randomly with default 640x480 -> exactly 638*478 windows, each matching a reference model.
